// File: rtl/uart_pkg.sv
// Shared UART definitions: frame parser state encoding, error causes and
// baud-rate timing helpers used by both the receiver and the command controller.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CHK     = 3'd4,
    HOLD    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ERR_OVERRUN = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CHK     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  localparam int DEFAULT_CLK_FREQ  = 25_000_000;
  localparam int DEFAULT_BAUD_RATE = 9600;

  // Clock cycles per UART bit; the receiver and the gap timer must agree on it.
  function automatic int bit_cycles(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  localparam int BIT_CYCLES = bit_cycles(DEFAULT_CLK_FREQ, DEFAULT_BAUD_RATE);

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap watchdog: reloads on every restart, counts down while enabled
// and strobes expire when a full period has passed without a restart.
module uart_gap_timer #(
  parameter int PERIOD = 104_160,
  localparam int W = $clog2(PERIOD)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  output logic expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart) begin
      count <= W'(PERIOD - 1);
    end else if (enable && count != '0) begin
      count <= count - 1'b1;
    end
  end

  // A restart in the expiry cycle wins, so a byte arriving just in time still counts.
  assign expire = enable && !restart && (count == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame parser behind the UART receiver: SOF, CMD, LEN, payload, XOR checksum.
// Good frames are held on a valid/ready port; bad or stalled frames raise err_pulse.
module uart_cmd_ctrl
  import uart_pkg::*;
#(
  parameter int         CLK_FREQ      = DEFAULT_CLK_FREQ,
  parameter int         BAUD_RATE     = DEFAULT_BAUD_RATE,
  parameter int         MAX_LEN       = 8,
  parameter int         TIMEOUT_BYTES = 4,
  parameter logic [7:0] SOF_BYTE      = SOF_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_ready,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           cmd_code,
  output logic [3:0]           cmd_len,
  output logic [8*MAX_LEN-1:0] cmd_payload,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  output logic                 busy
);

  localparam int GAP_CYCLES = bit_cycles(CLK_FREQ, BAUD_RATE) * 10 * TIMEOUT_BYTES;

  state_t     state;
  logic [7:0] chk;
  logic [3:0] idx;
  logic       timer_en;
  logic       timeout;

  assign timer_en = (state == CMD) || (state == LEN) || (state == PAYLOAD) || (state == CHK);
  assign busy     = (state != IDLE);

  uart_gap_timer #(
    .PERIOD (GAP_CYCLES)
  ) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (rx_ready),
    .enable  (timer_en),
    .expire  (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      cmd_len     <= '0;
      cmd_payload <= '0;
      err_pulse   <= 1'b0;
      err_code    <= '0;
      chk         <= '0;
      idx         <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE: begin
          // Clearing here keeps bytes beyond cmd_len zero even after an aborted frame.
          if (rx_ready && rx_data == SOF_BYTE) begin
            cmd_payload <= '0;
            state       <= CMD;
          end
        end
        CMD: begin
          if (rx_ready) begin
            cmd_code <= rx_data;
            chk      <= rx_data;
            state    <= LEN;
          end else if (timeout) begin
            err_pulse <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= IDLE;
          end
        end
        LEN: begin
          if (rx_ready) begin
            if (rx_data > 8'(MAX_LEN)) begin
              err_pulse <= 1'b1;
              err_code  <= ERR_LEN;
              state     <= IDLE;
            end else begin
              cmd_len <= rx_data[3:0];
              chk     <= chk ^ rx_data;
              idx     <= '0;
              state   <= (rx_data == 8'd0) ? CHK : PAYLOAD;
            end
          end else if (timeout) begin
            err_pulse <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= IDLE;
          end
        end
        PAYLOAD: begin
          if (rx_ready) begin
            cmd_payload[8*idx +: 8] <= rx_data;
            chk <= chk ^ rx_data;
            idx <= idx + 4'd1;
            if (idx + 4'd1 == cmd_len) state <= CHK;
          end else if (timeout) begin
            err_pulse <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= IDLE;
          end
        end
        CHK: begin
          if (rx_ready) begin
            if (rx_data == chk) begin
              cmd_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              err_pulse <= 1'b1;
              err_code  <= ERR_CHK;
              state     <= IDLE;
            end
          end else if (timeout) begin
            err_pulse <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= IDLE;
          end
        end
        HOLD: begin
          if (cmd_ready) begin
            cmd_valid   <= 1'b0;
            cmd_payload <= '0;
            state       <= IDLE;
          end
          // No buffering while holding a command: a new byte is lost and reported.
          if (rx_ready) begin
            err_pulse <= 1'b1;
            err_code  <= ERR_OVERRUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
